csr_axil_responder: RTL and testbench
=====================================

Name: csr_axil_responder

Overview:
- AXI-Lite responder that owns the machine-mode CSR state.
- Sits opposite the pipeline's CSR read port (execute) and CSR write port (commit); serves one read and one write transaction concurrently.
- Also captures trap state (mepc/mcause/mtval) from commit and counts cycles/retired instructions.

Parameters:
MISA_VALUE, 32'h40000100, read-only misa contents (RV32I)
MHARTID, 0, read-only mhartid contents
MTVEC_RESET, 32'h00000000, mtvec value after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
axil_csr_araddr  input  12  read address (CSR number)
axil_csr_arvalid  input  1  read address valid
axil_csr_arready  output  1  read address accepted
axil_csr_rdata  output  32  read data
axil_csr_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR
axil_csr_rvalid  output  1  read data valid
axil_csr_rready  input  1  read data taken
axil_csr_awaddr  input  12  write address
axil_csr_awvalid  input  1  write address valid
axil_csr_awready  output  1  write address accepted
axil_csr_wdata  input  32  write data
axil_csr_wvalid  input  1  write data valid
axil_csr_wready  output  1  write data accepted
axil_csr_bresp  output  3  bit2 always 0; [1:0] as rresp
axil_csr_bvalid  output  1  write response valid
axil_csr_bready  input  1  write response taken
trap_valid  input  1  commit exception strobe
trap_cause  input  6  exception number -> mcause[5:0]
trap_val  input  32  -> mtval
trap_pc  input  32  -> mepc
retire  input  1  one instruction retired this cycle
mtvec_out  output  32  current mtvec

Behaviour:
- Reset (reset=0, async):
  - arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - mtvec=MTVEC_RESET; all other writable CSRs and counters = 0.
- CSR map (anything else is illegal):
  - RW: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mcycle 0xB00 / mcycleh 0xB80 and minstret 0xB02 / minstreth 0xB82: RW halves of 64-bit counters.
  - RO: misa 0x301, mhartid 0xF14, cycle 0xC00 / cycleh 0xC80, instret 0xC02 / instreth 0xC82.
  - mepc[1:0] always reads 0; mcause bit31 reads 0; mcause[30:6] reads 0.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready=1. On arvalid, decode the address combinationally, register rdata/rresp, go to R_RESP (rvalid=1 the next cycle; latency 1).
  - R_RESP: arready=0; rvalid, rdata and rresp held stable until rready. On rready -> R_IDLE; arready=1 the following cycle (no back-to-back acceptance).
  - Illegal address: rdata=0, rresp=2'b10.
- Write FSM, states W_IDLE, W_HAVE_A, W_HAVE_D and W_RESP:
  - AW and W are accepted independently in any order or in the same cycle. Each ready drops once its beat is captured.
  - When both are held (including same-cycle arrival), the write is applied on that edge and the FSM enters W_RESP with bvalid=1 the next cycle.
  - W_RESP: awready=wready=0 until bready, then -> W_IDLE.
  - Illegal or RO address: no state change, bresp=3'b010. Otherwise bresp=0.
- Counters:
  - mcycle increments every cycle (64-bit wrap from all-ones to 0).
  - minstret increments when retire=1.
  - A CSR write to either half replaces that half and suppresses that counter's increment in the same cycle (written value is exact).
  - Carry from low to high half is applied in the same cycle.
- Traps:
  - trap_valid=1 writes mepc=trap_pc & ~3, mcause={26'b0,trap_cause}, mtval=trap_val.
  - If a CSR write targets mepc/mcause/mtval on the same edge, the trap wins for that register. The response is still OKAY.
- Read/write same CSR same cycle: read returns the pre-write value.
- mtvec_out is the registered mtvec, valid at all times.

Test Plan:
- Reset: hold reset=0 with arvalid=1 -> arready=1, rvalid=0, bvalid=0, mtvec_out=MTVEC_RESET. Read 0x301 after release -> rdata=32'h40000100, rresp=0, rvalid exactly 1 cycle after the AR handshake.
- Write ordering: W (32'hDEADBEEF) presented 3 cycles before AW 0x340 -> single bvalid, bresp=0. Read 0x340 -> 32'hDEADBEEF. Repeat with same-cycle AW/W -> identical result.
- Backpressure: hold rready=0 for 5 cycles -> rvalid/rdata stable, arready=0 throughout. Hold bready=0 -> awready=wready=0 until bready.
- Errors: read 0x7FF -> rresp=2'b10, rdata=0. Write 0xF14 -> bresp=3'b010, subsequent read of 0xF14 = MHARTID.
- Counters: write mcycle=32'hFFFFFFFF, mcycleh=0 -> two cycles later mcycleh reads 1, mcycle small. With retire pulsed 4 times, instret increases by 4.
- Trap collision: trap_valid with trap_pc=32'h1003, trap_cause=6'd2 on the same edge as a CSR write of 32'h55 to 0x341 -> mepc reads 32'h1000, mcause reads 2, bresp=0.

Source files
------------

// File: rtl/csr_axil_responder.sv
// AXI-Lite responder owning the machine-mode CSR file, trap capture and the
// mcycle/minstret counters; one read and one write transaction in flight at once.
module csr_axil_responder #(
   parameter logic [31:0] MISA_VALUE  = 32'h40000100,
   parameter logic [31:0] MHARTID     = 32'h00000000,
   parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] axil_csr_araddr,
   input  logic        axil_csr_arvalid,
   output logic        axil_csr_arready,
   output logic [31:0] axil_csr_rdata,
   output logic [1:0]  axil_csr_rresp,
   output logic        axil_csr_rvalid,
   input  logic        axil_csr_rready,
   input  logic [11:0] axil_csr_awaddr,
   input  logic        axil_csr_awvalid,
   output logic        axil_csr_awready,
   input  logic [31:0] axil_csr_wdata,
   input  logic        axil_csr_wvalid,
   output logic        axil_csr_wready,
   output logic [2:0]  axil_csr_bresp,
   output logic        axil_csr_bvalid,
   input  logic        axil_csr_bready,
   input  logic        trap_valid,
   input  logic [5:0]  trap_cause,
   input  logic [31:0] trap_val,
   input  logic [31:0] trap_pc,
   input  logic        retire,
   output logic [31:0] mtvec_out
);

   typedef enum logic [0:0] {R_IDLE, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;

   r_state_t r_state;
   w_state_t w_state;

   logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mtval;
   logic [5:0]  mcause;
   logic [63:0] mcycle, minstret;

   logic [11:0] awaddr_q;
   logic [31:0] wdata_q;

   logic        rd_legal;
   logic [31:0] rd_val;

   logic        a_avail, d_avail, wr_fire, wr_ok;
   logic [11:0] wr_addr;
   logic [31:0] wr_data;

   function automatic logic csr_writable(input logic [11:0] addr);
      case (addr)
         12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
         12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // Read decode sees the pre-edge register values, so a same-cycle write is not visible.
   always_comb begin
      rd_legal = 1'b1;
      rd_val   = 32'h0;
      case (axil_csr_araddr)
         12'h300: rd_val = mstatus;
         12'h304: rd_val = mie;
         12'h305: rd_val = mtvec;
         12'h340: rd_val = mscratch;
         12'h341: rd_val = mepc;
         12'h342: rd_val = {26'h0, mcause};
         12'h343: rd_val = mtval;
         12'h301: rd_val = MISA_VALUE;
         12'hF14: rd_val = MHARTID;
         12'hB00, 12'hC00: rd_val = mcycle[31:0];
         12'hB80, 12'hC80: rd_val = mcycle[63:32];
         12'hB02, 12'hC02: rd_val = minstret[31:0];
         12'hB82, 12'hC82: rd_val = minstret[63:32];
         default: rd_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= R_IDLE;
         axil_csr_arready <= 1'b1;
         axil_csr_rvalid  <= 1'b0;
         axil_csr_rdata   <= 32'h0;
         axil_csr_rresp   <= 2'b00;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (axil_csr_arvalid) begin
                  axil_csr_rdata   <= rd_val;
                  axil_csr_rresp   <= rd_legal ? 2'b00 : 2'b10;
                  axil_csr_rvalid  <= 1'b1;
                  axil_csr_arready <= 1'b0;
                  r_state          <= R_RESP;
               end
            end
            R_RESP: begin
               if (axil_csr_rready) begin
                  axil_csr_rvalid  <= 1'b0;
                  axil_csr_arready <= 1'b1;
                  r_state          <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // A beat is available either from its holding register or from a handshake this cycle.
   always_comb begin
      a_avail = (w_state == W_HAVE_A) || (axil_csr_awvalid && axil_csr_awready);
      d_avail = (w_state == W_HAVE_D) || (axil_csr_wvalid && axil_csr_wready);
      wr_fire = a_avail && d_avail;
      wr_addr = (w_state == W_HAVE_A) ? awaddr_q : axil_csr_awaddr;
      wr_data = (w_state == W_HAVE_D) ? wdata_q : axil_csr_wdata;
      wr_ok   = wr_fire && csr_writable(wr_addr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state          <= W_IDLE;
         axil_csr_awready <= 1'b1;
         axil_csr_wready  <= 1'b1;
         axil_csr_bvalid  <= 1'b0;
         axil_csr_bresp   <= 3'b000;
         awaddr_q         <= 12'h0;
         wdata_q          <= 32'h0;
      end else if (wr_fire) begin
         w_state          <= W_RESP;
         axil_csr_awready <= 1'b0;
         axil_csr_wready  <= 1'b0;
         axil_csr_bvalid  <= 1'b1;
         axil_csr_bresp   <= wr_ok ? 3'b000 : 3'b010;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (axil_csr_awvalid) begin
                  awaddr_q         <= axil_csr_awaddr;
                  axil_csr_awready <= 1'b0;
                  w_state          <= W_HAVE_A;
               end else if (axil_csr_wvalid) begin
                  wdata_q          <= axil_csr_wdata;
                  axil_csr_wready  <= 1'b0;
                  w_state          <= W_HAVE_D;
               end
            end
            W_HAVE_A, W_HAVE_D: ;
            W_RESP: begin
               if (axil_csr_bready) begin
                  axil_csr_bvalid  <= 1'b0;
                  axil_csr_awready <= 1'b1;
                  axil_csr_wready  <= 1'b1;
                  w_state          <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Trap capture has priority over a colliding CSR write to the same register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mstatus  <= 32'h0;
         mie      <= 32'h0;
         mtvec    <= MTVEC_RESET;
         mscratch <= 32'h0;
         mepc     <= 32'h0;
         mcause   <= 6'h0;
         mtval    <= 32'h0;
         mcycle   <= 64'h0;
         minstret <= 64'h0;
      end else begin
         if (wr_ok && wr_addr == 12'h300) mstatus  <= wr_data;
         if (wr_ok && wr_addr == 12'h304) mie      <= wr_data;
         if (wr_ok && wr_addr == 12'h305) mtvec    <= wr_data;
         if (wr_ok && wr_addr == 12'h340) mscratch <= wr_data;

         if (trap_valid)                       mepc <= trap_pc & ~32'h3;
         else if (wr_ok && wr_addr == 12'h341) mepc <= wr_data & ~32'h3;

         if (trap_valid)                       mcause <= trap_cause;
         else if (wr_ok && wr_addr == 12'h342) mcause <= wr_data[5:0];

         if (trap_valid)                       mtval <= trap_val;
         else if (wr_ok && wr_addr == 12'h343) mtval <= wr_data;

         if (wr_ok && wr_addr == 12'hB00)      mcycle[31:0]  <= wr_data;
         else if (wr_ok && wr_addr == 12'hB80) mcycle[63:32] <= wr_data;
         else                                  mcycle <= mcycle + 64'd1;

         if (wr_ok && wr_addr == 12'hB02)      minstret[31:0]  <= wr_data;
         else if (wr_ok && wr_addr == 12'hB82) minstret[63:32] <= wr_data;
         else if (retire)                      minstret <= minstret + 64'd1;
      end
   end

   assign mtvec_out = mtvec;

endmodule

// File: tb/tb_csr_axil_responder.sv
// Bench for csr_axil_responder: directed scenarios plus a randomized CSR
// read/write mix checked against an address-keyed model of the CSR file.
module tb_csr_axil_responder;

   localparam logic [31:0] MISA_VALUE  = 32'h40000100;
   localparam logic [31:0] MHARTID     = 32'h00000000;
   localparam logic [31:0] MTVEC_RESET = 32'h00000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [11:0] awaddr;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic        wvalid, wready;
   logic [2:0]  bresp;
   logic        bvalid, bready;
   logic        trap_valid;
   logic [5:0]  trap_cause;
   logic [31:0] trap_val, trap_pc;
   logic        retire;
   logic [31:0] mtvec_out;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] model [int];

   always #5 clk = ~clk;

   csr_axil_responder #(
      .MISA_VALUE (MISA_VALUE),
      .MHARTID    (MHARTID),
      .MTVEC_RESET(MTVEC_RESET)
   ) dut (
      .clk(clk), .reset(reset),
      .axil_csr_araddr(araddr), .axil_csr_arvalid(arvalid), .axil_csr_arready(arready),
      .axil_csr_rdata(rdata), .axil_csr_rresp(rresp), .axil_csr_rvalid(rvalid),
      .axil_csr_rready(rready),
      .axil_csr_awaddr(awaddr), .axil_csr_awvalid(awvalid), .axil_csr_awready(awready),
      .axil_csr_wdata(wdata), .axil_csr_wvalid(wvalid), .axil_csr_wready(wready),
      .axil_csr_bresp(bresp), .axil_csr_bvalid(bvalid), .axil_csr_bready(bready),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_val(trap_val),
      .trap_pc(trap_pc), .retire(retire), .mtvec_out(mtvec_out)
   );

   // Reference view of the CSR map: raw values stored, architectural masking on read.
   function automatic void model_read(input logic [11:0] a, output logic [31:0] v,
                                      output logic [1:0] resp);
      resp = 2'b00;
      case (a)
         12'h300, 12'h304, 12'h305, 12'h340, 12'h343: v = model[int'(a)];
         12'h341: v = model[int'(a)] & 32'hFFFF_FFFC;
         12'h342: v = model[int'(a)] & 32'h0000_003F;
         12'h301: v = MISA_VALUE;
         12'hF14: v = MHARTID;
         default: begin v = 32'h0; resp = 2'b10; end
      endcase
   endfunction

   function automatic logic [2:0] model_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: begin
            model[int'(a)] = d;
            return 3'b000;
         end
         default: return 3'b010;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
      bit hs = 0;
      bit hs_now;
      ok = 1;
      araddr  = a;
      arvalid = 1'b1;
      for (int k = 0; k < 20 && !hs; k++) begin
         hs_now = arready;
         tick();
         hs = hs_now;
      end
      arvalid = 1'b0;
      if (!hs || rvalid !== 1'b1) ok = 0;
      d    = rdata;
      resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
      if (rvalid !== 1'b0) ok = 0;
   endtask

   // w_lead > 0: W leads AW by that many cycles; < 0: AW leads; 0: same cycle.
   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input int w_lead,
                            input bit trap_en, input int bready_delay,
                            output logic [2:0] resp, output bit ok);
      int  astart = (w_lead > 0) ? w_lead : 0;
      int  wstart = (w_lead < 0) ? -w_lead : 0;
      bit  ad = 0, wd = 0, ahs, whs;
      ok = 1;
      awaddr = a;
      wdata  = d;
      for (int k = 0; k < 40 && !(ad && wd); k++) begin
         awvalid    = !ad && (k >= astart);
         wvalid     = !wd && (k >= wstart);
         ahs        = awvalid && awready;
         whs        = wvalid && wready;
         trap_valid = trap_en && (ad || ahs) && (wd || whs);
         tick();
         if (ahs) ad = 1;
         if (whs) wd = 1;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      trap_valid = 1'b0;
      if (!(ad && wd) || bvalid !== 1'b1) ok = 0;
      resp = bresp;
      for (int k = 0; k < bready_delay; k++) begin
         if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1 || bresp !== resp) ok = 0;
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) ok = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      bit          ok;
      reset   = 1'b0;
      araddr  = 12'h301;
      arvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_handshake got ar/aw/w/r/b=%b want 11100",
                     {arready, awready, wready, rvalid, bvalid});
         end
      end
      n_cmp++;
      if (mtvec_out !== MTVEC_RESET || rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_values got mtvec=%h rdata=%h rresp=%b bresp=%b want %h/0/0/0",
                  mtvec_out, rdata, rresp, bresp, MTVEC_RESET);
      end
      arvalid = 1'b0;
      reset   = 1'b1;
      tick();
      axi_read(12'h301, d, r, ok);
      n_cmp++;
      if (!ok || d !== MISA_VALUE || r !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_misa got ok=%0d data=%h resp=%b want 1/%h/00", ok, d, r, MISA_VALUE);
      end
   endtask

   task automatic test_write_order();
      logic [31:0] d;
      logic [1:0]  r;
      logic [2:0]  b;
      bit          ok;
      int          leads [3] = '{3, 0, -2};
      logic [31:0] vals  [3] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h0BADF00D};
      for (int i = 0; i < 3; i++) begin
         axi_write(12'h340, vals[i], leads[i], 1'b0, 0, b, ok);
         void'(model_write(12'h340, vals[i]));
         n_cmp++;
         if (!ok || b !== 3'b000) begin
            n_fail++;
            $display("FAIL write_order_%0d got ok=%0d bresp=%b want 1/000", leads[i], ok, b);
         end
         axi_read(12'h340, d, r, ok);
         n_cmp++;
         if (!ok || d !== vals[i] || r !== 2'b00) begin
            n_fail++;
            $display("FAIL readback_%0d got ok=%0d data=%h resp=%b want 1/%h/00",
                     leads[i], ok, d, r, vals[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d0;
      logic [2:0]  b;
      bit          ok, stable;
      araddr  = 12'h340;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      d0 = rdata;
      stable = (rvalid === 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) stable = 0;
      end
      n_cmp++;
      if (!stable || d0 !== model[12'h340]) begin
         n_fail++;
         $display("FAIL read_backpressure got stable=%0d data=%h want 1/%h", stable, d0, model[12'h340]);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      n_cmp++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         n_fail++;
         $display("FAIL read_release got rvalid=%b arready=%b want 0/1", rvalid, arready);
      end
      axi_write(12'h304, 32'h0000_0888, 1, 1'b0, 6, b, ok);
      void'(model_write(12'h304, 32'h0000_0888));
      n_cmp++;
      if (!ok || b !== 3'b000) begin
         n_fail++;
         $display("FAIL write_backpressure got ok=%0d bresp=%b want 1/000", ok, b);
      end
   endtask

   task automatic test_errors();
      logic [31:0] d;
      logic [1:0]  r;
      logic [2:0]  b;
      bit          ok;
      axi_read(12'h7FF, d, r, ok);
      n_cmp++;
      if (!ok || d !== 32'h0 || r !== 2'b10) begin
         n_fail++;
         $display("FAIL read_illegal got ok=%0d data=%h resp=%b want 1/0/10", ok, d, r);
      end
      axi_write(12'hF14, 32'h1234_5678, 0, 1'b0, 0, b, ok);
      n_cmp++;
      if (!ok || b !== 3'b010) begin
         n_fail++;
         $display("FAIL write_ro got ok=%0d bresp=%b want 1/010", ok, b);
      end
      axi_read(12'hF14, d, r, ok);
      n_cmp++;
      if (!ok || d !== MHARTID || r !== 2'b00) begin
         n_fail++;
         $display("FAIL mhartid_kept got data=%h resp=%b want %h/00", d, r, MHARTID);
      end
      axi_write(12'hC00, 32'h0, -1, 1'b0, 0, b, ok);
      n_cmp++;
      if (!ok || b !== 3'b010) begin
         n_fail++;
         $display("FAIL write_cycle_ro got ok=%0d bresp=%b want 1/010", ok, b);
      end
   endtask

   task automatic test_counters();
      logic [31:0] d;
      logic [1:0]  r;
      logic [2:0]  b;
      bit          ok;
      axi_write(12'hB80, 32'h0, 0, 1'b0, 0, b, ok);
      axi_write(12'hB00, 32'hFFFF_FFFF, 0, 1'b0, 0, b, ok);
      axi_read(12'hB80, d, r, ok);
      n_cmp++;
      if (!ok || d !== 32'h1 || r !== 2'b00) begin
         n_fail++;
         $display("FAIL mcycleh_carry got data=%h resp=%b want 1/00", d, r);
      end
      axi_read(12'hC00, d, r, ok);
      n_cmp++;
      if (!ok || d >= 32'd64) begin
         n_fail++;
         $display("FAIL mcycle_small got data=%h want below 64", d);
      end
      axi_write(12'hB82, 32'h0, 0, 1'b0, 0, b, ok);
      axi_write(12'hB02, 32'd100, 2, 1'b0, 0, b, ok);
      axi_read(12'hB02, d, r, ok);
      n_cmp++;
      if (!ok || d !== 32'd100) begin
         n_fail++;
         $display("FAIL minstret_write got data=%0d want 100", d);
      end
      for (int k = 0; k < 4; k++) begin
         retire = 1'b1;
         tick();
         retire = 1'b0;
         tick();
      end
      axi_read(12'hC02, d, r, ok);
      n_cmp++;
      if (!ok || d !== 32'd104) begin
         n_fail++;
         $display("FAIL instret_count got data=%0d want 104", d);
      end
   endtask

   task automatic test_trap_collision();
      logic [31:0] d, tv;
      logic [1:0]  r;
      logic [2:0]  b;
      bit          ok;
      tv         = $urandom;
      trap_pc    = 32'h0000_1003;
      trap_cause = 6'd2;
      trap_val   = tv;
      axi_write(12'h341, 32'h55, 0, 1'b1, 0, b, ok);
      model[12'h341] = 32'h0000_1003;
      model[12'h342] = 32'd2;
      model[12'h343] = tv;
      n_cmp++;
      if (!ok || b !== 3'b000) begin
         n_fail++;
         $display("FAIL trap_bresp got ok=%0d bresp=%b want 1/000", ok, b);
      end
      axi_read(12'h341, d, r, ok);
      n_cmp++;
      if (d !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL trap_mepc got %h want 00001000", d);
      end
      axi_read(12'h342, d, r, ok);
      n_cmp++;
      if (d !== 32'd2) begin
         n_fail++;
         $display("FAIL trap_mcause got %h want 00000002", d);
      end
      axi_read(12'h343, d, r, ok);
      n_cmp++;
      if (d !== tv) begin
         n_fail++;
         $display("FAIL trap_mtval got %h want %h", d, tv);
      end
   endtask

   task automatic test_random_mix();
      logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h301, 12'hF14, 12'h7FF, 12'h123};
      logic [11:0] a;
      logic [31:0] d, ev, wv;
      logic [1:0]  r, er;
      logic [2:0]  b, eb;
      bit          ok;
      for (int i = 0; i < 40; i++) begin
         a = addrs[$urandom_range(10, 0)];
         if ($urandom_range(1, 0) == 1) begin
            wv = $urandom;
            eb = model_write(a, wv);
            axi_write(a, wv, $urandom_range(6, 0) - 3, 1'b0, $urandom_range(2, 0), b, ok);
            n_cmp++;
            if (!ok || b !== eb) begin
               n_fail++;
               $display("FAIL rand_write[%0d] addr=%h got ok=%0d bresp=%b want 1/%b", i, a, ok, b, eb);
            end
            n_cmp++;
            if (mtvec_out !== model[12'h305]) begin
               n_fail++;
               $display("FAIL rand_mtvec_out[%0d] got %h want %h", i, mtvec_out, model[12'h305]);
            end
         end else begin
            model_read(a, ev, er);
            axi_read(a, d, r, ok);
            n_cmp++;
            if (!ok || d !== ev || r !== er) begin
               n_fail++;
               $display("FAIL rand_read[%0d] addr=%h got ok=%0d data=%h resp=%b want 1/%h/%b",
                        i, a, ok, d, r, ev, er);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      arvalid = 0; araddr = 0; rready = 0;
      awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; bready = 0;
      trap_valid = 0; trap_cause = 0; trap_val = 0; trap_pc = 0; retire = 0;
      foreach (model[k]) model.delete(k);
      model[12'h300] = 0; model[12'h304] = 0; model[12'h305] = MTVEC_RESET;
      model[12'h340] = 0; model[12'h341] = 0; model[12'h342] = 0; model[12'h343] = 0;
      test_reset();
      test_write_order();
      test_backpressure();
      test_errors();
      test_counters();
      test_trap_collision();
      test_random_mix();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
